// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
// Shared types and helpers for the bit-serial adder.
//   state_t   : FSM state encoding (IDLE / SHIFT / DONE)
//   cnt_width : width of the bit counter for a given operand width
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // The counter must be able to hold WIDTH (its value after the last
  // shift) without wrapping, hence clog2(WIDTH+1). Never narrower than 1.
  function automatic int cnt_width(input int w);
    int r;
    r = $clog2(w + 1);
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/full_adder.sv
// full_adder
// Existing 1-bit full adder cell.
// Ports:
//   x, y : addend bits (in)
//   z    : carry in (in)
//   s    : sum bit (out)
//   c    : carry out (out)
module full_adder (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic s,
  output logic c
);

  assign s = x ^ y ^ z;
  assign c = (x & y) | (x & z) | (y & z);

endmodule

// File: rtl/serial_adder.sv
// serial_adder
// Bit-serial WIDTH-bit adder using a single full_adder cell and a carry
// flip-flop. Operands load on an accepted start, one bit is added per clock
// (LSB first) and the parallel result is presented with a one-cycle done.
// Parameters:
//   WIDTH : operand/sum width, 1..64
// Ports:
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset
//   start : request pulse, sampled only while idle
//   a, b  : operands, captured on the accepted start edge
//   cin   : carry-in, captured on the accepted start edge
//   busy  : high while shifting or presenting the result
//   done  : one-cycle pulse, sum/cout valid
//   sum   : result, held until the next accepted start
//   cout  : carry out of the MSB, held with sum
//   ovf   : signed overflow (only when SERIAL_ADDER_OVF_EN is defined)
// Configuration macro: SERIAL_ADDER_OVF_EN adds the ovf output.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [CW-1:0]    r_cnt;

  logic             w_s;
  logic             w_c;
  logic             w_last;
  logic [WIDTH-1:0] w_sum_shift;

  full_adder u_fa (
    .x (r_a_sr[0]),
    .y (r_b_sr[0]),
    .z (r_carry),
    .s (w_s),
    .c (w_c)
  );

  assign w_last = (r_cnt == LAST);

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands at sum[0].
  // Written as a shifted concatenation so WIDTH=1 needs no special case.
  assign w_sum_shift = WIDTH'({w_s, r_sum} >> 1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start)  w_state_next = SHIFT;
      SHIFT:   if (w_last) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Outputs: done is high exactly for the single DONE cycle
  always_comb begin
    busy = (r_state != IDLE);
    done = (r_state == DONE);
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a_sr  <= a;
            r_b_sr  <= b;
            r_carry <= cin;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
          end
        end
        SHIFT: begin
          r_a_sr  <= r_a_sr >> 1;
          r_b_sr  <= r_b_sr >> 1;
          r_sum   <= w_sum_shift;
          r_carry <= w_c;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            r_cout <= w_c;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

`ifdef SERIAL_ADDER_OVF_EN
  logic r_ovf;

  // While the MSB is being added, r_carry is the carry into the MSB; its
  // disagreement with the carry out marks a two's-complement overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_ovf <= 1'b0;
    end else if (r_state == SHIFT && w_last) begin
      r_ovf <= r_carry ^ w_c;
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder
// Scoreboarded bench for serial_adder (WIDTH=8). Stimulus pushes the
// hand-computed result of each accepted operation; a monitor pops and
// compares whenever done is seen, including the start-to-done latency.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  typedef struct {
    logic [W-1:0] esum;
    logic         ecout;
    logic         eovf;
    int           cyc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  int   dones  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every done pulse against the oldest expectation
  always @(negedge clk) begin
    if (!rst && done) begin
      dones++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected none pending (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("sum", 64'(sum), 64'(e.esum));
        check("cout", 64'(cout), 64'(e.ecout));
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf", 64'(ovf), 64'(e.eovf));
`endif
        check("latency", 64'(cyc - e.cyc), 64'(W + 1));
        $display("done: sum=%02h cout=%0b expected sum=%02h cout=%0b", sum, cout, e.esum, e.ecout);
      end
    end
  end

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: got %0d pending results expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic do_add(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                        input logic [W-1:0] es, input logic ec, input logic eo);
    exp_t e;
    @(negedge clk);
    start = 1'b1;
    a = va;
    b = vb;
    cin = vc;
    e.esum = es; e.ecout = ec; e.eovf = eo; e.cyc = cyc;
    q.push_back(e);
    $display("issue: a=%02h b=%02h cin=%0b", va, vb, vc);
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    cin = 1'($urandom);
    wait_drain();
  endtask

  // Directed vectors: a, b, cin, expected sum, cout, ovf
  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vc;
    logic [W-1:0] es;
    logic         ec;
    logic         eo;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[4] = '{8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1};
    vecs[5] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state held while idle
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_busy", 64'(busy), 64'(0));
      check("idle_done", 64'(done), 64'(0));
      check("idle_sum", 64'(sum), 64'(0));
      check("idle_cout", 64'(cout), 64'(0));
    end
    $display("reset/idle: busy=%0b done=%0b sum=%02h cout=%0b", busy, done, sum, cout);

    foreach (vecs[i]) begin
      do_add(vecs[i].va, vecs[i].vb, vecs[i].vc, vecs[i].es, vecs[i].ec, vecs[i].eo);
    end

    // Start while busy is ignored: only 10+20 completes
    begin
      exp_t e;
      int   d0;
      d0 = dones;
      @(negedge clk);
      start = 1'b1; a = 8'h10; b = 8'h20; cin = 1'b0;
      e.esum = 8'h30; e.ecout = 1'b0; e.eovf = 1'b0; e.cyc = cyc;
      q.push_back(e);
      $display("issue: a=10 b=20 cin=0 (second start while busy follows)");
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      check("busy_during_shift", 64'(busy), 64'(1));
      start = 1'b1; a = 8'h01; b = 8'h01;
      @(negedge clk);
      start = 1'b0;
      wait_drain();
      repeat (W + 4) @(negedge clk);
      check("single_done", 64'(dones - d0), 64'(1));
      check("sum_held", 64'(sum), 64'(8'h30));
    end

    // Reset mid-operation aborts without a done pulse
    begin
      int d0;
      @(negedge clk);
      start = 1'b1; a = 8'h11; b = 8'h22; cin = 1'b0;
      $display("issue: a=11 b=22 cin=0 (to be aborted)");
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_busy", 64'(busy), 64'(0));
      check("abort_done", 64'(done), 64'(0));
      check("abort_sum", 64'(sum), 64'(0));
      check("abort_cout", 64'(cout), 64'(0));
      d0 = dones;
      repeat (W + 4) @(negedge clk);
      check("abort_no_done", 64'(dones - d0), 64'(0));
      $display("abort: busy=%0b sum=%02h cout=%0b", busy, sum, cout);
    end

    do_add(8'h02, 8'h03, 1'b0, 8'h05, 1'b0, 1'b0);

    // rst and start on the same edge: rst wins
    @(negedge clk);
    rst = 1'b1; start = 1'b1; a = 8'h01; b = 8'h01;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rst_wins_busy", 64'(busy), 64'(0));
    check("rst_wins_sum", 64'(sum), 64'(0));
    $display("rst+start: busy=%0b sum=%02h", busy, sum);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
